// File: rtl/pack_coalesce.sv
// pack_coalesce: merges lane-contiguous partial beats into dense N-lane beats.
// Leftover lanes wait in a staging buffer until N lanes accumulate or the
// frame ends. Optional partial-beat timeout flush: PACK_COALESCE_TIMEOUT_EN.

// Per-lane merge slice. Lane J of the merged beat comes from the staging
// buffer when J < occ, otherwise from the input shifted up by occ. The spill
// lane (input lane J+N-occ, used to refill the buffer after a full beat) has
// the same index modulo N, so a single mux serves both.
module pack_coalesce_lane #(
  parameter int N = 8,
  parameter int W = 32,
  parameter int J = 0
) (
  input  logic [N-1:0][W-1:0] in_w,
  input  logic [W-1:0]        buf_lane,
  input  logic [$clog2(N):0]  occ,
  output logic [W-1:0]        merged,
  output logic [W-1:0]        shifted
);
  localparam int LW = $clog2(N);

  logic [LW:0] diff;

  assign diff    = (LW+1)'(J) - occ;
  assign shifted = in_w[diff[LW-1:0]];
  assign merged  = ((LW+1)'(J) < occ) ? buf_lane : shifted;
endmodule

module pack_coalesce #(
  parameter int N   = 8,
  parameter int W   = 32,
  parameter int TMO = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [N-1:0][W-1:0] in_w,
  input  logic [N-1:0]        in_msk,
  input  logic                in_last,
  output logic                out_vld_r,
  input  logic                out_rdy,
  output logic [N-1:0][W-1:0] out_r,
  output logic [N-1:0]        out_msk_r,
  output logic                out_last_r
);
  localparam int LW = $clog2(N);
  localparam int OW = LW + 1;
  localparam int CW = LW + 2;

  typedef enum logic {ACC, FLUSH} state_t;

  if (N < 2 || (N & (N - 1)) != 0 || W < 1 || TMO < 1) begin : g_bad_param
    $error("pack_coalesce: N must be a power of two >= 2, W and TMO >= 1");
  end

  state_t             state;
  logic [OW-1:0]      occ;
  logic [N-1:0][W-1:0] stage_buf;
  logic [N-1:0][W-1:0] merged;
  logic [N-1:0][W-1:0] shifted;
  logic [CW-1:0]      k;
  logic [CW-1:0]      c;
  logic               slot_free;
  logic               acc;
  logic               tmo_fire;

  function automatic logic [N-1:0] thermo(input logic [CW-1:0] n);
    logic [N-1:0] m;
    for (int j = 0; j < N; j++) m[j] = (CW'(j) < n);
    return m;
  endfunction

  for (genvar j = 0; j < N; j++) begin : g_lane
    pack_coalesce_lane #(.N(N), .W(W), .J(j)) u_lane (
      .in_w     (in_w),
      .buf_lane (stage_buf[j]),
      .occ      (occ),
      .merged   (merged[j]),
      .shifted  (shifted[j])
    );
  end

  // Lane count of the incoming beat and the merged total.
  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++) k = k + CW'(in_msk[i]);
  end
  assign c = CW'(occ) + k;

  assign slot_free = ~out_vld_r | out_rdy;
  assign in_rdy    = (state == ACC) & slot_free & ~tmo_fire;
  assign acc       = in_vld & in_rdy;

`ifdef PACK_COALESCE_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_fire = (state == ACC) & (occ != '0) & (tmo_cnt == TW'(TMO)) & slot_free;

  // Idle counter: runs while partial lanes sit unaccepted, saturates at TMO.
  always_ff @(posedge clk) begin
    if (rst)                                               tmo_cnt <= '0;
    else if (acc || tmo_fire)                              tmo_cnt <= '0;
    else if (state == ACC && occ != '0 && tmo_cnt != TW'(TMO)) tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Accumulate / emit FSM with registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      out_msk_r  <= '0;
      out_last_r <= 1'b0;
      occ        <= '0;
      state      <= ACC;
    end else begin
      if (out_rdy) out_vld_r <= 1'b0;
      case (state)
        ACC: begin
          if (acc) begin
            if (c >= CW'(N)) begin
              out_vld_r <= 1'b1;
              out_r     <= merged;
              out_msk_r <= '1;
              stage_buf <= shifted;
              occ       <= OW'(c - CW'(N));
              out_last_r <= in_last && (c == CW'(N));
              if (in_last && c != CW'(N)) state <= FLUSH;
            end else if (!in_last) begin
              stage_buf <= merged;
              occ       <= OW'(c);
            end else begin
              out_vld_r  <= 1'b1;
              out_r      <= merged;
              out_msk_r  <= thermo(c);
              out_last_r <= 1'b1;
              occ        <= '0;
            end
          end else if (tmo_fire) begin
            out_vld_r  <= 1'b1;
            out_r      <= stage_buf;
            out_msk_r  <= thermo(CW'(occ));
            out_last_r <= 1'b0;
            occ        <= '0;
          end
        end
        FLUSH: begin
          if (slot_free) begin
            out_vld_r  <= 1'b1;
            out_r      <= stage_buf;
            out_msk_r  <= thermo(CW'(occ));
            out_last_r <= 1'b1;
            occ        <= '0;
            state      <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule

// File: doc/pack_coalesce.md
Name: pack_coalesce

Overview:
- Merges the partially-filled packed vectors produced by the lane-pack stage into fully-populated N-lane beats.
- Input beats are lane-contiguous: valid lanes occupy 0..k-1.
- The block holds leftover lanes in a staging buffer and emits a beat once N lanes are available or a frame ends.
- Sits directly downstream of the pack stage and upstream of wide consumers (FIFO/egress) that need dense beats. Valid/ready handshake on both sides.

Parameters:
- N, 8, lane count per beat (power of two, >=2).
- W, 32, lane data width in bits.
- TMO, 16, idle cycles before a partial-beat timeout flush (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_vld  in  1  input beat valid
- in_rdy  out  1  input beat accepted when in_vld & in_rdy
- in_w  in  N*W  input lanes, [N-1:0][W-1:0]
- in_msk  in  N  thermometer lane-valid mask (bit 0 upward)
- in_last  in  1  final beat of frame
- out_vld_r  out  1  output beat valid (registered)
- out_rdy  in  1  downstream ready
- out_r  out  N*W  output lanes (registered)
- out_msk_r  out  N  thermometer lane-valid mask of output beat
- out_last_r  out  1  output beat closes frame

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - out_vld_r=0, out_msk_r=0, out_last_r=0.
  - occ=0, state=ACC, timeout counter=0.
  - out_r and the staging buffer buf[N] are not reset.
- State:
  - occ: staging-buffer occupancy, width $clog2(N)+1, range 0..N-1 at rest.
  - FSM states: ACC and FLUSH.
- Output slot: free when ~out_vld_r | out_rdy. out_vld_r clears on out_rdy unless a new beat loads in the same cycle.
- in_rdy = (state==ACC) & slot free. Combinational from out_vld_r, out_rdy and state only; never depends on in_vld.
- On accept: k = popcount(in_msk) and c = occ + k, where c < 2N.
- Merged lane j is buf[j] if j < occ, else in_w[j-occ].
- Case c >= N:
  - Load the output register with merged lanes 0..N-1, msk all ones.
  - New buf[j] = in_w[j+N-occ] for j < c-N; occ <= c-N.
  - If in_last and c == N: out_last_r=1, occ=0.
  - If in_last and c > N: out_last_r=0, state <= FLUSH.
- Case c < N, not last:
  - buf takes the merged lanes, occ <= c, no output beat.
- Case c < N, last:
  - Emit the merged lanes, out_msk_r = ~('1 << c), out_last_r=1, occ=0.
  - c == 0 emits an empty beat (msk 0, last 1) to carry the frame boundary.
- FLUSH:
  - in_rdy=0.
  - When the slot is free, emit buf with msk = ~('1 << occ) and last=1; occ <= 0; state <= ACC.
- Latency: the output beat is visible the cycle after the accepting edge.
- Backpressure: while out_vld_r & ~out_rdy, out_r, out_msk_r and out_last_r are held stable and in_rdy=0.
- in_vld without in_rdy: no state change.
- Non-thermometer in_msk is a protocol violation and the result is undefined. The bench flags it with an assertion.
- Reset mid-frame or mid-FLUSH: buffered lanes are discarded; the next accepted beat starts at occ=0.
- Arithmetic: occ, k and c are computed at $clog2(N)+2 bits, so there is no wrap.

Optional Feature:
- Macro: PACK_COALESCE_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in ACC with occ > 0 and no input accepted; any accept clears it.
  - When the counter reaches TMO and the slot is free, emit buf as a partial beat: msk = ~('1 << occ), last=0. Then occ <= 0 and the counter clears.
  - in_rdy is 0 in that flush cycle.
- Not defined: no counter logic. Partial lanes wait indefinitely for more input or in_last.

Test Plan (N=4, W=8):
1. occ=0; accept msk 0011 {A0,A1}, then msk 0111 {B0,B1,B2}, out_rdy=1 -> next cycle out_r={B1,B0,A1,A0}, msk 1111, last 0; occ=1 holding B2.
2. occ=3 {C0,C1,C2}; accept msk 0111 {D0,D1,D2} with last:
   - Cycle +1: beat {D0,C2,C1,C0}, msk 1111, last 0; in_rdy=0 (FLUSH).
   - Cycle +2: beat {D2,D1}, msk 0011, last 1.
   - in_rdy returns to 1.
3. Output beat held with out_rdy=0 for 5 cycles -> in_rdy=0 throughout; out_r/msk/last unchanged; the beat completes on the first out_rdy=1 cycle.
4. occ=0; accept msk 0000 with last -> beat msk 0000, last 1; occ stays 0.
5. PACK_COALESCE_TIMEOUT_EN, TMO=16: accept msk 0001 {E0}, then in_vld=0 -> 16 idle cycles later beat {E0}, msk 0001, last 0. Without the macro, no beat appears after 100 cycles.
6. Assert rst for one cycle during FLUSH with occ=2 -> out_vld_r=0 the next cycle and no flush beat. Then accept msk 1111 -> full beat of only the new data.
